// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, registered response.
// Define ALU_ARB_PERF_EN to add per-requester grant counters with clear.
module alu_share_core #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 5
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [OP_W-1:0]   i_op,
   output logic [DATA_W-1:0] o_res,
   output logic              o_err
);
   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] w_sh;

   assign w_sh = i_b[SH_W-1:0];

   always_comb begin
      o_res = '0;
      o_err = 1'b0;
      unique case (i_op)
         5'b00000: o_res = i_a + i_b;
         5'b01000: o_res = i_a - i_b;
         5'b00100: o_res = i_a ^ i_b;
         5'b00110: o_res = i_a | i_b;
         5'b00111: o_res = i_a & i_b;
         5'b00001: o_res = i_a << w_sh;
         5'b00101: o_res = i_a >> w_sh;
         5'b01101: o_res = $signed(i_a) >>> w_sh;
         5'b00010: o_res = {{(DATA_W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
         5'b00011: o_res = {{(DATA_W-1){1'b0}}, i_a < i_b};
         5'b11111: o_res = i_b;
         default:  o_err = 1'b1;
      endcase
   end
endmodule

module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [DATA_W-1:0] r0_b,
   input  logic [OP_W-1:0]   r0_op,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [DATA_W-1:0] r1_b,
   input  logic [OP_W-1:0]   r1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_res,
   output logic              rsp_err
`ifdef ALU_ARB_PERF_EN
   ,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
`endif
);
   localparam int SH_W = $clog2(DATA_W);

   typedef enum logic {S_IDLE, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last_grant;
   logic                r_rsp_id;
   logic [DATA_W-1:0]   r_rsp_res;
   logic                r_rsp_err;
   logic                w_can_accept;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_accept;
   logic [DATA_W-1:0]   w_a;
   logic [DATA_W-1:0]   w_b;
   logic [DATA_W-1:0]   w_alu_b;
   logic [OP_W-1:0]     w_op;
   logic                w_is_sh;
   logic [DATA_W-1:0]   w_res;
   logic                w_err;

   // r_last_grant=1 means requester 1 won last, so requester 0 wins a tie
   always_comb begin
      w_state_nxt  = r_state;
      w_can_accept = 1'b0;
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      if (rst_n) begin
         w_can_accept = (r_state == S_IDLE) | rsp_ready;
         if (r0_valid & r1_valid) begin
            w_gnt0 = w_can_accept & r_last_grant;
            w_gnt1 = w_can_accept & ~r_last_grant;
         end else begin
            w_gnt0 = w_can_accept & r0_valid;
            w_gnt1 = w_can_accept & r1_valid;
         end
      end
      w_accept = w_gnt0 | w_gnt1;
      unique case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_RESP;
         S_RESP: if (rsp_ready & ~w_accept) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   assign w_a     = w_gnt1 ? r1_a  : r0_a;
   assign w_b     = w_gnt1 ? r1_b  : r0_b;
   assign w_op    = w_gnt1 ? r1_op : r0_op;
   assign w_is_sh = (w_op == 5'b00001) | (w_op == 5'b00101) |
                    (w_op == 5'b01101);
   assign w_alu_b = w_is_sh ? {{(DATA_W-SH_W){1'b0}}, w_b[SH_W-1:0]}
                            : w_b;

   alu_share_core #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .i_a   (w_a),
      .i_b   (w_alu_b),
      .i_op  (w_op),
      .o_res (w_res),
      .o_err (w_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_rsp_id     <= 1'b0;
         r_rsp_res    <= '0;
         r_rsp_err    <= 1'b0;
      end else if (w_accept) begin
         r_last_grant <= w_gnt1;
         r_rsp_id     <= w_gnt1;
         r_rsp_res    <= w_res;
         r_rsp_err    <= w_err;
      end
   end

   assign r0_ready  = w_gnt0;
   assign r1_ready  = w_gnt1;
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_res   = r_rsp_res;
   assign rsp_err   = r_rsp_err;

`ifdef ALU_ARB_PERF_EN
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_gnt0 && r_cnt0 != {CNT_W{1'b1}}) r_cnt0 <= r_cnt0 + 1'b1;
         if (w_gnt1 && r_cnt1 != {CNT_W{1'b1}}) r_cnt1 <= r_cnt1 + 1'b1;
      end
   end

   assign grant_cnt0 = r_cnt0;
   assign grant_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and random checks of alu_share_arbiter against a behavioural model.
// Define ALU_ARB_PERF_EN to also check the grant counters.
module tb_alu_share_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic [4:0]  r0_op, r1_op;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0] rsp_res;
`ifdef ALU_ARB_PERF_EN
   logic        cnt_clr;
   logic [15:0] grant_cnt0, grant_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   // model state
   logic        m_valid = 0, m_id = 0, m_err = 0;
   logic [31:0] m_res = 0;
   logic        m_r0_next = 1;
   int          m_c0 = 0, m_c1 = 0;
   logic        seen0, seen1;

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready),
      .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready),
      .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err)
`ifdef ALU_ARB_PERF_EN
      , .cnt_clr(cnt_clr)
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] ref_alu(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int sh;
      sh = b % 32;
      case (op)
         5'd0:  return {1'b0, a + b};
         5'd8:  return {1'b0, a - b};
         5'd4:  return {1'b0, a ^ b};
         5'd6:  return {1'b0, a | b};
         5'd7:  return {1'b0, a & b};
         5'd1:  return {1'b0, a << sh};
         5'd5:  return {1'b0, a >> sh};
         5'd13: return {1'b0, 32'($signed(a) >>> sh)};
         5'd2:  return {1'b0, 31'd0, $signed(a) < $signed(b)};
         5'd3:  return {1'b0, 31'd0, a < b};
         5'd31: return {1'b0, b};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   task automatic step(input logic rn,
                       input logic v0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [4:0] op0,
                       input logic v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [4:0] op1,
                       input logic rr, input logic clr);
      logic can, e0, e1, win;
      logic [32:0] r;
      @(negedge clk);
      rst_n = rn; rsp_ready = rr;
      r0_valid = v0; r0_a = a0; r0_b = b0; r0_op = op0;
      r1_valid = v1; r1_a = a1; r1_b = b1; r1_op = op1;
`ifdef ALU_ARB_PERF_EN
      cnt_clr = clr;
`endif
      #1;
      can = rn && (!m_valid || rr);
      // both asking: the one not served last time wins
      if (v0 && v1) win = m_r0_next ? 1'b0 : 1'b1;
      else          win = v1;
      e0 = can && (v0 || v1) && !win;
      e1 = can && (v0 || v1) && win;
      seen0 = r0_ready; seen1 = r1_ready;
      chk("r0_ready", {31'd0, r0_ready}, {31'd0, e0});
      chk("r1_ready", {31'd0, r1_ready}, {31'd0, e1});
      @(posedge clk);
      if (!rn) begin
         m_valid = 0; m_id = 0; m_res = 0; m_err = 0; m_r0_next = 1;
         m_c0 = 0; m_c1 = 0;
      end else begin
         if (e0 || e1) begin
            r = e1 ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
            m_valid = 1; m_id = e1; m_res = r[31:0]; m_err = r[32];
            m_r0_next = e1;
         end else if (m_valid && rr) begin
            m_valid = 0;
         end
         if (clr) begin
            m_c0 = 0; m_c1 = 0;
         end else begin
            if (e0 && m_c0 < 65535) m_c0++;
            if (e1 && m_c1 < 65535) m_c1++;
         end
      end
      #1;
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      chk("rsp_res", rsp_res, m_res);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
`ifdef ALU_ARB_PERF_EN
      chk("grant_cnt0", {16'd0, grant_cnt0}, m_c0);
      chk("grant_cnt1", {16'd0, grant_cnt1}, m_c1);
`endif
   endtask

   initial begin
      logic        h0, h1, pid;
      logic [31:0] a0, b0, a1, b1, prev;
      logic [4:0]  o0, o1;
      logic [4:0]  ops [12];
      ops = '{5'd0, 5'd8, 5'd4, 5'd6, 5'd7, 5'd1, 5'd5, 5'd13,
              5'd2, 5'd3, 5'd31, 5'd15};
      rst_n = 0; rsp_ready = 1;
      r0_valid = 0; r1_valid = 0;
      r0_a = 0; r0_b = 0; r0_op = 0; r1_a = 0; r1_b = 0; r1_op = 0;
`ifdef ALU_ARB_PERF_EN
      cnt_clr = 0;
`endif
      // 1: reset, single ADD from r0
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("t1_rst_valid", {31'd0, rsp_valid}, 0);
      chk("t1_rst_res", rsp_res, 0);
      step(1, 1, 5, 7, 5'd0, 0, 0, 0, 0, 1, 0);
      chk("t1_ready", {31'd0, seen0}, 1);
      chk("t1_res", rsp_res, 12);
      chk("t1_id", {31'd0, rsp_id}, 0);
      // 2: both valid, alternating grants
      pid = rsp_id;
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 3, 5, 5'd8, 1, 32'h8000_0000, 36, 5'd13, 1, 0);
         chk("t2_alt", {31'd0, rsp_id}, {31'd0, ~pid});
         chk("t2_res", rsp_res, rsp_id ? 32'hF800_0000 : 32'hFFFF_FFFE);
         chk("t2_valid", {31'd0, rsp_valid}, 1);
         pid = rsp_id;
      end
      // 3: stalled response blocks r1
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 9, 4, 5'd6, 0, 0, 0, 0, 0, 0);
      prev = rsp_res;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, 1, 32'hA5, 32'h0F, 5'd7, 0, 0);
         chk("t3_blocked", {31'd0, seen1}, 0);
         chk("t3_stable", rsp_res, prev);
      end
      step(1, 0, 0, 0, 0, 1, 32'hA5, 32'h0F, 5'd7, 1, 0);
      chk("t3_accept", {31'd0, seen1}, 1);
      chk("t3_res", rsp_res, 32'h05);
      // 4: unsupported op then SLTU
      step(1, 0, 0, 0, 0, 1, 32'h1234, 32'h5678, 5'd15, 1, 0);
      chk("t4_err", {31'd0, rsp_err}, 1);
      chk("t4_res0", rsp_res, 0);
      step(1, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 5'd3, 1, 0);
      chk("t4_sltu", rsp_res, 1);
      chk("t4_noerr", {31'd0, rsp_err}, 0);
      // 5: reset mid-response, r0 first afterwards
      step(0, 1, 1, 1, 5'd0, 1, 2, 2, 5'd0, 0, 0);
      chk("t5_flush", {31'd0, rsp_valid}, 0);
      step(1, 1, 1, 1, 5'd0, 1, 2, 2, 5'd0, 1, 0);
      chk("t5_r0_first", {31'd0, seen0}, 1);
`ifdef ALU_ARB_PERF_EN
      // 6: grant counters and clear
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) step(1, 1, i, 1, 5'd0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 1, i, 1, 5'd0, 1, 0);
      chk("t6_cnt0", {16'd0, grant_cnt0}, 4);
      chk("t6_cnt1", {16'd0, grant_cnt1}, 2);
      step(1, 1, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1);
      chk("t6_clr0", {16'd0, grant_cnt0}, 0);
      chk("t6_clr1", {16'd0, grant_cnt1}, 0);
`endif
      // random traffic; pending requests are held until accepted
      h0 = 0; h1 = 0;
      a0 = 0; b0 = 0; o0 = 0; a1 = 0; b1 = 0; o1 = 0;
      for (int i = 0; i < 400; i++) begin
         logic rn, rr, clr;
         if (!h0) begin
            a0 = $urandom; b0 = $urandom; o0 = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) o0 = 5'($urandom);
         end
         if (!h1) begin
            a1 = $urandom; b1 = $urandom; o1 = ops[$urandom_range(0, 11)];
         end
         rn  = ($urandom_range(0, 49) != 0);
         rr  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 63) == 0);
         h0 = h0 | ($urandom_range(0, 2) != 0);
         h1 = h1 | ($urandom_range(0, 2) != 0);
         step(rn, h0, a0, b0, o0, h1, a1, b1, o1, rr, clr);
         h0 = h0 & ~seen0 & rn;
         h1 = h1 & ~seen1 & rn;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
